// File: rtl/serdesphy_link_ctrl.sv
// serdesphy_link_ctrl: SerDes PHY link bring-up sequencer (PLL, CDR, optional PRBS qualification, retrain, sticky fail)
// Define SERDESPHY_PRBS_QUAL_EN to qualify the link with a PRBS error window before declaring link-up.
module serdesphy_link_ctrl #(
    parameter int PLL_TIMEOUT = 4096,
    parameter int CDR_TIMEOUT = 8192,
    parameter int PRBS_WINDOW = 1024,
    parameter int ERR_THRESH  = 4,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_en,
    input  logic       por_complete,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    input  logic       prbs_err,
    output logic       pll_en,
    output logic       cdr_en,
    output logic       prbs_chk_en,
    output logic       tx_en,
    output logic       link_up,
    output logic       link_fail,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLL_WAIT = 3'd1,
        CDR_WAIT = 3'd2,
        PRBS_CHK = 3'd3,
        LINK_UP  = 3'd4,
        RETRAIN  = 3'd5,
        FAIL     = 3'd6
    } state_t;
    localparam logic [15:0] PLL_LAST  = 16'(PLL_TIMEOUT - 1);
    localparam logic [15:0] CDR_LAST  = 16'(CDR_TIMEOUT - 1);
    localparam logic [15:0] WIN_LAST  = 16'(PRBS_WINDOW - 1);
    localparam logic [15:0] HOLD_LAST = 16'd7;
    localparam logic [7:0]  ERR_MAX   = 8'(ERR_THRESH);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);
`ifdef SERDESPHY_PRBS_QUAL_EN
    localparam bit     PRBS_ON  = 1'b1;
    localparam state_t CDR_DONE = PRBS_CHK;
`else
    localparam bit     PRBS_ON  = 1'b0;
    localparam state_t CDR_DONE = LINK_UP;
`endif
    state_t      st, nxt;
    logic [1:0]  pll_sync, cdr_sync;
    logic        pll_s, cdr_s;
    logic [15:0] timer;
    assign pll_s = pll_sync[1];
    assign cdr_s = cdr_sync[1];
    assign state = st;
`ifdef SERDESPHY_PRBS_QUAL_EN
    logic [7:0] err_cnt;
    // Count PRBS error cycles during the current state visit, saturating at 255
    always_ff @(posedge clk) begin
        if (!rst_n || nxt != st) err_cnt <= '0;
        else if (prbs_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`else
    logic unused_prbs;
    assign unused_prbs = prbs_err ^ (|WIN_LAST) ^ (|ERR_MAX);
`endif
    // Next-state selection: abort to IDLE first, then lock/window events, then timeouts
    always_comb begin
        nxt = st;
        if (!link_en || !por_complete) nxt = IDLE;
        else begin
            case (st)
                IDLE:     nxt = PLL_WAIT;
                PLL_WAIT: nxt = pll_s ? CDR_WAIT : (timer == PLL_LAST) ? RETRAIN : PLL_WAIT;
                CDR_WAIT: nxt = !pll_s ? RETRAIN : cdr_s ? CDR_DONE : (timer == CDR_LAST) ? RETRAIN : CDR_WAIT;
`ifdef SERDESPHY_PRBS_QUAL_EN
                PRBS_CHK: nxt = (!pll_s || !cdr_s || err_cnt >= ERR_MAX) ? RETRAIN : (timer == WIN_LAST) ? LINK_UP : PRBS_CHK;
`endif
                LINK_UP:  nxt = (!pll_s || !cdr_s) ? RETRAIN : LINK_UP;
                RETRAIN:  nxt = (timer != HOLD_LAST) ? RETRAIN : (retry_cnt == RETRY_MAX) ? FAIL : PLL_WAIT;
                FAIL:     nxt = FAIL;
                default:  nxt = IDLE;
            endcase
        end
    end
    // State, lock synchronizers, timer, retry count and outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= IDLE;
            pll_sync    <= '0;
            cdr_sync    <= '0;
            timer       <= '0;
            retry_cnt   <= '0;
            pll_en      <= 1'b0;
            cdr_en      <= 1'b0;
            prbs_chk_en <= 1'b0;
            tx_en       <= 1'b0;
            link_up     <= 1'b0;
            link_fail   <= 1'b0;
        end else begin
            pll_sync    <= {pll_sync[0], pll_lock};
            cdr_sync    <= {cdr_sync[0], cdr_lock};
            st          <= nxt;
            timer       <= (nxt != st) ? '0 : timer + 16'd1;
            retry_cnt   <= (nxt == IDLE || (nxt == LINK_UP && st != LINK_UP)) ? 2'd0 :
                           (nxt == RETRAIN && st != RETRAIN && retry_cnt != 2'd3) ? retry_cnt + 2'd1 : retry_cnt;
            pll_en      <= nxt inside {PLL_WAIT, CDR_WAIT, PRBS_CHK, LINK_UP};
            cdr_en      <= nxt inside {CDR_WAIT, PRBS_CHK, LINK_UP};
            prbs_chk_en <= PRBS_ON && (nxt inside {PRBS_CHK, LINK_UP});
            tx_en       <= nxt inside {PRBS_CHK, LINK_UP};
            link_up     <= nxt == LINK_UP;
            link_fail   <= nxt == FAIL;
        end
    end
endmodule

// File: tb/tb_serdesphy_link_ctrl.sv
// tb_serdesphy_link_ctrl: randomized scenarios checked against an edge-timeline model of the bring-up sequence
module tb_serdesphy_link_ctrl;
    localparam int PLLT = 64;
    localparam int CDRT = 64;
    localparam int WIN  = 32;
    localparam int ETH  = 4;
    localparam int MAXR = 3;
    localparam int HOLD = 8;
    localparam int NE   = 512;
`ifdef SERDESPHY_PRBS_QUAL_EN
    localparam bit PQ = 1'b1;
`else
    localparam bit PQ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, link_en, por_complete, pll_lock, cdr_lock, prbs_err;
    logic pll_en, cdr_en, prbs_chk_en, tx_en, link_up, link_fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [8:0] obs;

    int checks = 0;
    int passed = 0;

    logic d_rst[NE], d_en[NE], d_por[NE], d_pll[NE], d_cdr[NE], d_err[NE];
    int         exp_st[NE];
    logic [1:0] exp_rc[NE];
    bit         exp_ok[NE];

    serdesphy_link_ctrl #(
        .PLL_TIMEOUT(PLLT), .CDR_TIMEOUT(CDRT), .PRBS_WINDOW(WIN), .ERR_THRESH(ETH), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link_en(link_en), .por_complete(por_complete),
        .pll_lock(pll_lock), .cdr_lock(cdr_lock), .prbs_err(prbs_err),
        .pll_en(pll_en), .cdr_en(cdr_en), .prbs_chk_en(prbs_chk_en), .tx_en(tx_en),
        .link_up(link_up), .link_fail(link_fail), .state(state), .retry_cnt(retry_cnt)
    );

    assign obs = {pll_en, cdr_en, prbs_chk_en, tx_en, link_up, link_fail, state};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Output table per state code: {pll_en,cdr_en,prbs_chk_en,tx_en,link_up,link_fail,state}
    function automatic logic [8:0] exp_out(input int s);
        logic pll, cdr, prbs, tx, up, fl;
        pll  = s >= 1 && s <= 4;
        cdr  = s >= 2 && s <= 4;
        prbs = PQ && (s == 3 || s == 4);
        tx   = s == 3 || s == 4;
        up   = s == 4;
        fl   = s == 6;
        return {pll, cdr, prbs, tx, up, fl, 3'(s)};
    endfunction

    task automatic clear_plan();
        for (int k = 0; k < NE; k++) begin
            d_rst[k] = 1'b1; d_en[k] = 1'b1; d_por[k] = 1'b1;
            d_pll[k] = 1'b0; d_cdr[k] = 1'b0; d_err[k] = 1'b0;
            exp_ok[k] = 1'b0; exp_st[k] = 0; exp_rc[k] = 2'd0;
        end
    endtask

    // which: 0 link_en, 1 por_complete, 2 pll_lock, 3 cdr_lock, 4 rst_n; level from edge a onward
    task automatic set_lvl(input int which, input int a, input logic v);
        for (int k = a; k < NE; k++) begin
            if (which == 0) d_en[k] = v;
            else if (which == 1) d_por[k] = v;
            else if (which == 2) d_pll[k] = v;
            else if (which == 3) d_cdr[k] = v;
            else d_rst[k] = v;
        end
    endtask

    task automatic fill(input int a, input int b, input int s, input int rc);
        for (int k = a; k < b && k < NE; k++) begin
            exp_st[k] = s; exp_rc[k] = 2'(rc); exp_ok[k] = 1'b1;
        end
    endtask

    // Bring-up from PLL_WAIT entered at edge s; pv/cv are the first edges the FSM can see each lock
    task automatic bringup(input int s, input int pv, input int cv, input int rc, output int up);
        int ce, ae;
        ce = mx(pv, s + 1);
        ae = mx(cv, ce + 1);
        fill(s, ce, 1, rc);
        fill(ce, ae, 2, rc);
        up = PQ ? ae + WIN : ae;
        fill(ae, up, 3, rc);
        fill(up, NE, 4, 0);
    endtask

    task automatic drive(input int k);
        rst_n = d_rst[k]; link_en = d_en[k]; por_complete = d_por[k];
        pll_lock = d_pll[k]; cdr_lock = d_cdr[k]; prbs_err = d_err[k];
    endtask

    task automatic do_reset();
        rst_n = 1'b0; link_en = 1'b0; por_complete = 1'b0;
        pll_lock = 1'b0; cdr_lock = 1'b0; prbs_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; link_en = 1'b1; por_complete = 1'b1;
        pll_lock = 1'b1; cdr_lock = 1'b1; prbs_err = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 9'd0) $display("FAIL reset edge %0d: outputs got %b want %b", k, obs, 9'd0);
            else passed++;
            checks++;
            if (retry_cnt !== 2'd0) $display("FAIL reset edge %0d: retry_cnt got %0d want 0", k, retry_cnt);
            else passed++;
        end
    endtask

    task automatic test_bringup(input int p, input int c, input string nm);
        int up, n;
        clear_plan();
        set_lvl(2, p, 1'b1);
        set_lvl(3, c, 1'b1);
        if (!PQ) for (int k = 0; k < NE; k++) d_err[k] = 1'($urandom_range(0, 1));
        fill(0, 1, 0, 0);
        bringup(1, p + 3, c + 3, 0, up);
        n = up + 4;
        do_reset();
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (exp_ok[k]) begin
                checks++;
                if (obs !== exp_out(exp_st[k])) $display("FAIL %s edge %0d: outputs got %b want %b", nm, k, obs, exp_out(exp_st[k]));
                else passed++;
                checks++;
                if (retry_cnt !== exp_rc[k]) $display("FAIL %s edge %0d: retry_cnt got %0d want %0d", nm, k, retry_cnt, exp_rc[k]);
                else passed++;
            end
            drive(k);
        end
    endtask

    // a failed PLL attempts before lock; a == MAXR ends in FAIL released by link_en (sig 0) or por_complete (sig 1)
    task automatic test_pll_timeout(input int a, input int sig, input string nm);
        int s, n, d, ce;
        clear_plan();
        fill(0, 1, 0, 0);
        for (int k = 0; k < a; k++) begin
            s = 1 + k * (PLLT + HOLD);
            fill(s, s + PLLT, 1, k);
            fill(s + PLLT, s + PLLT + HOLD, 5, k + 1);
        end
        s = 1 + a * (PLLT + HOLD);
        if (a == MAXR) begin
            fill(s, s + 6, 6, MAXR);
            set_lvl(sig, s + 5, 1'b0);
            fill(s + 6, s + 10, 0, 0);
            n = s + 9;
        end else begin
            d = int'($urandom_range(0, 30));
            ce = s + d + 3;
            set_lvl(2, s + d, 1'b1);
            fill(s, ce, 1, a);
            fill(ce, ce + 3, 2, a);
            n = ce + 2;
        end
        do_reset();
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (exp_ok[k]) begin
                checks++;
                if (obs !== exp_out(exp_st[k])) $display("FAIL %s edge %0d: outputs got %b want %b", nm, k, obs, exp_out(exp_st[k]));
                else passed++;
                checks++;
                if (retry_cnt !== exp_rc[k]) $display("FAIL %s edge %0d: retry_cnt got %0d want %0d", nm, k, retry_cnt, exp_rc[k]);
                else passed++;
            end
            drive(k);
        end
    endtask

`ifdef SERDESPHY_PRBS_QUAL_EN
    // mode 0: 4 consecutive errors, 1: 3 errors, 2: 4th error on the last window cycle, else random count
    task automatic test_prbs_errors(input int mode);
        int p, c, ce, e, cnt, t4, target, j, j0, rr, n;
        bit slot[32];
        p = int'($urandom_range(0, 5));
        c = p + 1 + int'($urandom_range(0, 5));
        ce = p + 3;
        e = mx(c + 3, ce + 1);
        clear_plan();
        set_lvl(2, p, 1'b1);
        set_lvl(3, c, 1'b1);
        fill(0, 1, 0, 0);
        fill(1, ce, 1, 0);
        fill(ce, e, 2, 0);
        for (int i = 0; i < 32; i++) slot[i] = 1'b0;
        cnt = 0;
        if (mode == 0) begin
            j0 = int'($urandom_range(1, 20));
            for (int i = 0; i < 4; i++) slot[j0 + i] = 1'b1;
        end else begin
            target = (mode == 1 || mode == 2) ? 3 : int'($urandom_range(0, 7));
            while (cnt < target) begin
                j = int'($urandom_range(1, (mode == 2) ? 30 : 31));
                if (!slot[j]) begin slot[j] = 1'b1; cnt++; end
            end
            if (mode == 2) slot[31] = 1'b1;
        end
        cnt = 0;
        t4 = 0;
        for (int i = 1; i < 32; i++) if (slot[i]) begin
            d_err[e + i - 1] = 1'b1;
            cnt++;
            if (cnt == ETH) t4 = i;
        end
        if (t4 != 0) begin
            rr = e + t4 + 1;
            fill(e, rr, 3, 0);
            fill(rr, rr + HOLD, 5, 1);
            fill(rr + HOLD, rr + HOLD + 1, 1, 1);
            fill(rr + HOLD + 1, rr + HOLD + 2, 2, 1);
            fill(rr + HOLD + 2, rr + HOLD + 4, 3, 1);
            n = rr + HOLD + 3;
        end else begin
            fill(e, e + WIN, 3, 0);
            fill(e + WIN, e + WIN + 4, 4, 0);
            n = e + WIN + 3;
        end
        do_reset();
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (exp_ok[k]) begin
                checks++;
                if (obs !== exp_out(exp_st[k])) $display("FAIL prbs_err_m%0d edge %0d: outputs got %b want %b", mode, k, obs, exp_out(exp_st[k]));
                else passed++;
                checks++;
                if (retry_cnt !== exp_rc[k]) $display("FAIL prbs_err_m%0d edge %0d: retry_cnt got %0d want %0d", mode, k, retry_cnt, exp_rc[k]);
                else passed++;
            end
            drive(k);
        end
    endtask
`endif

    // which 0 drops cdr_lock in LINK_UP, 1 drops pll_lock; then relock and re-reach LINK_UP
    task automatic test_lock_loss(input int which);
        int p, c, up, d, r, x, pv, cv, up2, n;
        p = int'($urandom_range(0, 10));
        c = p + int'($urandom_range(1, 15));
        clear_plan();
        set_lvl(2, p, 1'b1);
        set_lvl(3, c, 1'b1);
        fill(0, 1, 0, 0);
        bringup(1, p + 3, c + 3, 0, up);
        d = int'($urandom_range(1, 10));
        r = up + d + 3;
        x = int'($urandom_range(1, 15));
        if (which == 0) begin
            set_lvl(3, up + d, 1'b0); set_lvl(3, r + x, 1'b1); pv = 0; cv = r + x + 3;
        end else begin
            set_lvl(2, up + d, 1'b0); set_lvl(2, r + x, 1'b1); pv = r + x + 3; cv = 0;
        end
        fill(r, r + HOLD, 5, 1);
        bringup(r + HOLD, pv, cv, 1, up2);
        n = up2 + 3;
        do_reset();
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (exp_ok[k]) begin
                checks++;
                if (obs !== exp_out(exp_st[k])) $display("FAIL lock_loss_%0d edge %0d: outputs got %b want %b", which, k, obs, exp_out(exp_st[k]));
                else passed++;
                checks++;
                if (retry_cnt !== exp_rc[k]) $display("FAIL lock_loss_%0d edge %0d: retry_cnt got %0d want %0d", which, k, retry_cnt, exp_rc[k]);
                else passed++;
            end
            drive(k);
        end
    endtask

    // kind 0: link_en low mid-CDR_WAIT, 1: por_complete low mid-CDR_WAIT, 2: rst_n low after CDR lock
    task automatic test_abort(input int kind);
        int p, c, ce, e, a, n;
        p = int'($urandom_range(0, 5));
        c = p + int'($urandom_range(12, 20));
        ce = p + 3;
        e = mx(c + 3, ce + 1);
        clear_plan();
        set_lvl(2, p, 1'b1);
        set_lvl(3, c, 1'b1);
        fill(0, 1, 0, 0);
        fill(1, ce, 1, 0);
        fill(ce, e, 2, 0);
        if (kind < 2) begin
            a = ce + int'($urandom_range(1, 5));
            set_lvl(kind, a, 1'b0);
            set_lvl(kind, a + 4, 1'b1);
            fill(a + 1, a + 5, 0, 0);
            fill(a + 5, a + 6, 1, 0);
            fill(a + 6, a + 7, 2, 0);
        end else begin
            a = e + int'($urandom_range(1, 5));
            set_lvl(4, a, 1'b0);
            set_lvl(4, a + 3, 1'b1);
            fill(e, a + 1, PQ ? 3 : 4, 0);
            fill(a + 1, a + 4, 0, 0);
            fill(a + 4, a + 6, 1, 0);
            fill(a + 6, a + 7, 2, 0);
        end
        n = a + 6;
        do_reset();
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (exp_ok[k]) begin
                checks++;
                if (obs !== exp_out(exp_st[k])) $display("FAIL abort_%0d edge %0d: outputs got %b want %b", kind, k, obs, exp_out(exp_st[k]));
                else passed++;
                checks++;
                if (retry_cnt !== exp_rc[k]) $display("FAIL abort_%0d edge %0d: retry_cnt got %0d want %0d", kind, k, retry_cnt, exp_rc[k]);
                else passed++;
            end
            drive(k);
        end
    endtask

    initial begin
        int p;
        test_reset();
        test_bringup(5, 12, "bringup_ref");
        for (int i = 0; i < 3; i++) begin
            p = int'($urandom_range(0, 15));
            test_bringup(p, p + int'($urandom_range(1, 20)), "bringup_rand");
        end
        test_pll_timeout(MAXR, 0, "fail_link_en");
        test_pll_timeout(MAXR, 1, "fail_por");
        test_pll_timeout(int'($urandom_range(0, 2)), 0, "pll_retry");
        test_pll_timeout(0, 0, "pll_first");
`ifdef SERDESPHY_PRBS_QUAL_EN
        for (int m = 0; m < 7; m++) test_prbs_errors(m);
`endif
        test_lock_loss(0);
        test_lock_loss(1);
        test_abort(0);
        test_abort(1);
        test_abort(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
